// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TDO return path: capture FSM encoding,
// field widths and the LENGTH clamping rule.
package jtag_pkg;

  localparam int LEN_W       = 6;
  localparam int CNT_FIELD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_PUSH    = 2'd2
  } cap_state_e;

  // Snapshot of the capture engine, for probing from outside the datapath.
  typedef struct packed {
    cap_state_e       state;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len;
  } cap_dbg_t;

  // LENGTH of zero means one bit; anything above the vector limit saturates.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int unsigned max_len);
    logic [LEN_W-1:0] res;
    res = len;
    if (len == '0) res = LEN_W'(1);
    else if (32'(len) > max_len) res = LEN_W'(max_len);
    return res;
  endfunction

endpackage

// File: rtl/jtag_tdo_fifo.sv
// Synchronous FIFO for captured words; full/empty come from read/write
// pointers carrying one extra wrap bit.
module jtag_tdo_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Push is qualified by the start-of-cycle full flag, so a same-cycle pop
  // never makes room for a word that arrived while full.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Storage is not reset; gating keeps the head word at zero while empty.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/jtag_tdo_capture.sv
// Captures TDO bits on rising TCK into words of up to C_S_AXIS_DATA_LENGTH bits
// and streams each finished word, tagged with its bit count, on AXI4-Stream.
//
// Stream handshake: a beat transfers on a CLK edge where M_AXIS_TVALID and
// M_AXIS_TREADY are both high; TVALID never drops and TDATA/TLAST never change
// while a beat is offered but not yet accepted.
module jtag_tdo_capture
  import jtag_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 64,
  parameter int C_S_AXIS_DATA_LENGTH = 32,
  parameter int C_TCK_CLOCK_RATIO    = 8,
  parameter int C_FIFO_DEPTH         = 16
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           TCK,
  input  logic                           TDO,
  input  logic                           START,
  input  logic [LEN_W-1:0]               LENGTH,
  input  logic                           LAST,
  output logic                           BUSY,
  output logic                           OVERFLOW,
  output logic [C_M_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                           M_AXIS_TLAST,
  output logic                           M_AXIS_TVALID,
  input  logic                           M_AXIS_TREADY
);

  localparam int SW = C_S_AXIS_DATA_LENGTH;
  localparam int MW = C_M_AXIS_DATA_WIDTH;

  cap_state_e       state;
  cap_state_e       state_next;
  logic             tdo_s1;
  logic             tdo_s2;
  logic             tck_q;
  logic             rise;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic             last_q;
  logic [SW-1:0]    shreg;
  logic [MW-1:0]    word;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [MW:0]      fifo_rdata;
  cap_dbg_t         dbg;

  // TDO is asynchronous; TCK is already CLK-synchronous and only needs
  // one register for its edge detector.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tdo_s1 <= 1'b0;
      tdo_s2 <= 1'b0;
      tck_q  <= 1'b0;
    end else begin
      tdo_s1 <= TDO;
      tdo_s2 <= tdo_s1;
      tck_q  <= TCK;
    end
  end

  assign rise = TCK && !tck_q;

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (rise && ((count + LEN_W'(1)) == len_q)) state_next = ST_PUSH;
      end
      ST_PUSH: begin
        push       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      len_q    <= LEN_W'(1);
      last_q   <= 1'b0;
      count    <= '0;
      shreg    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            len_q  <= clamp_len(LENGTH, SW);
            last_q <= LAST;
            count  <= '0;
            shreg  <= '0;
          end
        end
        ST_CAPTURE: begin
          // LSB first: bit n of the word is the n-th TDO sample.
          if (rise) begin
            shreg <= shreg | (SW'(tdo_s2) << count);
            count <= count + LEN_W'(1);
          end
        end
        ST_PUSH: begin
          if (fifo_full) OVERFLOW <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    word                    = '0;
    word[SW-1:0]            = shreg;
    word[SW +: CNT_FIELD_W] = CNT_FIELD_W'(count);
  end

  jtag_tdo_fifo #(
    .W     (MW + 1),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .wdata ({last_q, word}),
    .pop   (M_AXIS_TVALID && M_AXIS_TREADY),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign BUSY          = (state != ST_IDLE);
  assign M_AXIS_TVALID = !fifo_empty;
  assign M_AXIS_TLAST  = fifo_rdata[MW];
  assign M_AXIS_TDATA  = fifo_rdata[MW-1:0];

  assign dbg = '{state: state, count: count, len: len_q};

endmodule

// File: tb/tb_jtag_tdo_capture.sv
// Randomized bench for jtag_tdo_capture: a queue-based reference model
// predicts every streamed word from the bits and lengths the bench drives.
module tb_jtag_tdo_capture;

  localparam int MW    = 64;
  localparam int SW    = 32;
  localparam int RATIO = 8;
  localparam int HALF  = RATIO / 2;
  localparam int DEPTH = 16;
  localparam int CW    = MW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tck = 1'b0;
  logic          tdo = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    length = '0;
  logic          last = 1'b0;
  logic          busy;
  logic          overflow;
  logic [MW-1:0] tdata;
  logic          tlast;
  logic          tvalid;
  logic          tready = 1'b0;

  int            n_vec = 0;
  int            n_err = 0;
  int            n_beats = 0;
  int            ready_mode = 0;
  bit            model_ovf = 1'b0;
  bit            hold_prev = 1'b0;
  logic [CW-1:0] hold_data;
  logic [CW-1:0] exp_q[$];

  jtag_tdo_capture #(
    .C_M_AXIS_DATA_WIDTH  (MW),
    .C_S_AXIS_DATA_LENGTH (SW),
    .C_TCK_CLOCK_RATIO    (RATIO),
    .C_FIFO_DEPTH         (DEPTH)
  ) dut (
    .CLK           (clk),
    .RESET         (rst),
    .TCK           (tck),
    .TDO           (tdo),
    .START         (start),
    .LENGTH        (length),
    .LAST          (last),
    .BUSY          (busy),
    .OVERFLOW      (overflow),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tready = 1'b0;
      1:       tready = 1'b1;
      default: tready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // reference model: bit count saturates to 1..SW, data is masked to it
  function automatic logic [CW-1:0] model_word(input logic [5:0] len, input logic lst,
                                               input logic [31:0] data);
    int unsigned n;
    logic [63:0] mask;
    logic [63:0] w;
    n = (len == 0) ? 1 : ((len > SW) ? SW : len);
    mask = (64'd1 << n) - 64'd1;
    w = (64'(n) << SW) | (64'(data) & mask);
    return {lst, w};
  endfunction

  task automatic model_issue(input logic [CW-1:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else model_ovf = 1'b1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [CW-1:0] exp;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && tvalid) check("hold", {tlast, tdata}, hold_data);
      if (tvalid && tready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("beat", {tlast, tdata}, exp);
        n_beats++;
      end
      hold_prev = tvalid && !tready;
      hold_data = {tlast, tdata};
    end
  end

  // drivers
  task automatic drive_bits(input logic [31:0] data, input int n, input int restart_at,
                            input bit chk_lat);
    for (int i = 0; i < n; i++) begin
      tck = 1'b0;
      tdo = data[i];
      tick(HALF);
      tck = 1'b1;
      if (i == restart_at) begin
        start = 1'b1;
        length = 6'd3;
        tick(1);
        start = 1'b0;
        tick(HALF - 1);
      end else if (chk_lat && i == n - 1) begin
        tick(1);
        check("lat_t1_valid", CW'(tvalid), CW'(0));
        check("lat_t1_busy", CW'(busy), CW'(1));
        tick(1);
        check("lat_t2_valid", CW'(tvalid), CW'(1));
        tick(HALF - 2);
      end else begin
        tick(HALF);
      end
    end
  endtask

  task automatic shift_word(input logic [5:0] len, input logic lst, input logic [31:0] data,
                            input int restart_at, input bit chk_lat);
    int n;
    n = (len == 0) ? 1 : ((len > SW) ? SW : len);
    model_issue(model_word(len, lst, data));
    start = 1'b1;
    length = len;
    last = lst;
    tick(1);
    start = 1'b0;
    check("busy_after_start", CW'(busy), CW'(1));
    drive_bits(data, n, restart_at, chk_lat);
    tick(2);
  endtask

  task automatic drain();
    int t;
    ready_mode = 1;
    t = 0;
    while ((exp_q.size() != 0 || tvalid) && t < 300) begin
      tick(1);
      t++;
    end
    check("drain_left", CW'(exp_q.size()), CW'(0));
    check("drain_valid", CW'(tvalid), CW'(0));
  endtask

  // main sequence
  initial begin
    int beats0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_busy", CW'(busy), CW'(0));
    check("rst_ovf", CW'(overflow), CW'(0));
    check("rst_valid", CW'(tvalid), CW'(0));
    check("rst_data", {tlast, tdata}, CW'(0));

    // TCK toggling with nothing armed must not produce words
    ready_mode = 1;
    for (int i = 0; i < 6; i++) begin
      tck = 1'b0;
      tdo = 1'($urandom_range(0, 1));
      tick(HALF);
      tck = 1'b1;
      tick(HALF);
      check("idle_valid", CW'(tvalid), CW'(0));
      check("idle_busy", CW'(busy), CW'(0));
    end

    shift_word(6'd32, 1'b1, 32'hA5A5_0F0F, -1, 1'b1);
    drain();
    shift_word(6'd5, 1'b0, 32'h0000_000D, -1, 1'b1);
    drain();
    shift_word(6'd8, 1'b1, 32'($urandom), 3, 1'b0);
    drain();
    shift_word(6'd0, 1'b0, 32'($urandom), -1, 1'b0);
    shift_word(6'd45, 1'b1, 32'($urandom), -1, 1'b0);
    drain();

    ready_mode = 2;
    for (int k = 0; k < 20; k++) begin
      shift_word(6'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), 32'($urandom), -1, 1'b0);
    end
    drain();

    // fill the FIFO with TREADY low; the 17th word must be dropped
    ready_mode = 0;
    tick(2);
    beats0 = n_beats;
    for (int k = 0; k < DEPTH + 1; k++) begin
      shift_word(6'd1, 1'($urandom_range(0, 1)), 32'($urandom), -1, 1'b0);
      if (k == DEPTH - 1) check("ovf_at_16", CW'(overflow), CW'(model_ovf));
    end
    check("ovf_at_17", CW'(overflow), CW'(model_ovf));
    drain();
    check("ovf_beats", CW'(n_beats - beats0), CW'(DEPTH));
    check("ovf_sticky", CW'(overflow), CW'(model_ovf));

    // reset in the middle of a capture with words queued
    ready_mode = 0;
    for (int k = 0; k < 3; k++) shift_word(6'd4, 1'b0, 32'($urandom), -1, 1'b0);
    start = 1'b1;
    length = 6'd32;
    last = 1'b1;
    tick(1);
    start = 1'b0;
    drive_bits(32'($urandom), 10, -1, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    model_ovf = 1'b0;
    check("mid_rst_valid", CW'(tvalid), CW'(0));
    check("mid_rst_busy", CW'(busy), CW'(0));
    check("mid_rst_ovf", CW'(overflow), CW'(model_ovf));
    ready_mode = 1;
    shift_word(6'd12, 1'b1, 32'($urandom), -1, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
